// File: rtl/cc_bank_stack.sv
// Nested condition-code register file: bank 0 for run mode plus LEVELS interrupt
// banks, selected by a nesting counter or an explicit bank index.
module cc_bank_stack #(
    parameter int CC_W    = 4,
    parameter int LEVELS  = 2,
    parameter int INHERIT = 0,
    parameter int LW      = $clog2(LEVELS + 1)
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            FETCH,
    input  logic            CC_LD,
    input  logic            SEL_EN,
    input  logic [LW-1:0]   CC_SEL,
    input  logic [CC_W-1:0] CCIN,
    input  logic            INT_ENTER,
    input  logic            INT_EXIT,
    input  logic            CLR_ERR,
    output logic [CC_W-1:0] CCOUT,
    output logic [LW-1:0]   LEVEL,
    output logic            AT_MAX,
    output logic            OVF,
    output logic            UNF
);

    localparam int NB = LEVELS + 1;
    localparam logic [LW-1:0] MAX_LVL = LW'(LEVELS);

    logic [CC_W-1:0] bank_r   [NB];
    logic [CC_W-1:0] bank_nxt [NB];
    logic [LW-1:0]   level_r;
    logic [LW-1:0]   level_nxt;
    logic            ovf_r;
    logic            ovf_nxt;
    logic            unf_r;
    logic            unf_nxt;

    logic [LW-1:0]   idx_s;
    logic            idx_ok_s;
    logic            wr_s;
    logic            enter_s;
    logic            exit_s;
    logic            push_s;
    logic            pop_s;
    logic [CC_W-1:0] cur_s;
    logic [CC_W-1:0] out_val_s;
    logic [CC_W-1:0] rd_s;

    assign idx_s    = SEL_EN ? CC_SEL : level_r;
    assign idx_ok_s = (idx_s <= MAX_LVL);
    assign wr_s     = FETCH & CC_LD & idx_ok_s;
    assign enter_s  = INT_ENTER & ~INT_EXIT;
    assign exit_s   = INT_EXIT & ~INT_ENTER;
    assign push_s   = enter_s & (level_r != MAX_LVL);
    assign pop_s    = exit_s & (level_r != {LW{1'b0}});

    // Read mux for the addressed bank and the current (outgoing) bank.
    always_comb begin
        rd_s  = {CC_W{1'b0}};
        cur_s = {CC_W{1'b0}};
        for (int i = 0; i < NB; i++) begin
            if (idx_ok_s && (idx_s == LW'(i))) begin
                rd_s = bank_r[i];
            end else begin
                rd_s = rd_s;
            end
            if (level_r == LW'(i)) begin
                cur_s = bank_r[i];
            end else begin
                cur_s = cur_s;
            end
        end
    end

    // Outgoing bank value as it will stand after this edge, used for inheritance.
    assign out_val_s = (wr_s && (idx_s == level_r)) ? CCIN : cur_s;

    // Next-state for banks, level and sticky error flags.
    always_comb begin
        level_nxt = level_r;
        ovf_nxt   = ovf_r;
        unf_nxt   = unf_r;
        for (int i = 0; i < NB; i++) begin
            bank_nxt[i] = bank_r[i];
            if (push_s && (LW'(i) == level_r + LW'(1))) begin
                bank_nxt[i] = (INHERIT != 0) ? out_val_s : {CC_W{1'b0}};
            end else begin
                bank_nxt[i] = bank_nxt[i];
            end
            // An explicit write to the newly entered bank overrides clear/copy.
            if (wr_s && (LW'(i) == idx_s)) begin
                bank_nxt[i] = CCIN;
            end else begin
                bank_nxt[i] = bank_nxt[i];
            end
        end

        if (push_s) begin
            level_nxt = level_r + LW'(1);
        end else if (pop_s) begin
            level_nxt = level_r - LW'(1);
        end else begin
            level_nxt = level_r;
        end

        if (enter_s && (level_r == MAX_LVL)) begin
            ovf_nxt = 1'b1;
        end else if (CLR_ERR) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = ovf_r;
        end

        if (exit_s && (level_r == {LW{1'b0}})) begin
            unf_nxt = 1'b1;
        end else if (CLR_ERR) begin
            unf_nxt = 1'b0;
        end else begin
            unf_nxt = unf_r;
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NB; i++) begin
                bank_r[i] <= {CC_W{1'b0}};
            end
            level_r <= {LW{1'b0}};
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                bank_r[i] <= bank_nxt[i];
            end
            level_r <= level_nxt;
            ovf_r   <= ovf_nxt;
            unf_r   <= unf_nxt;
        end
    end

    assign CCOUT  = rd_s;
    assign LEVEL  = level_r;
    assign AT_MAX = (level_r == MAX_LVL);
    assign OVF    = ovf_r;
    assign UNF    = unf_r;

endmodule

// File: tb/tb_cc_bank_stack.sv
// Directed bench for cc_bank_stack: one instance without and one with entry inheritance,
// both driven by the same stimulus.
module tb_cc_bank_stack;

    localparam int CC_W   = 4;
    localparam int LEVELS = 2;
    localparam int LW     = $clog2(LEVELS + 1);

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            FETCH, CC_LD, SEL_EN, INT_ENTER, INT_EXIT, CLR_ERR;
    logic [LW-1:0]   CC_SEL;
    logic [CC_W-1:0] CCIN;

    logic [CC_W-1:0] ccout0, ccout1;
    logic [LW-1:0]   level0, level1;
    logic            at_max0, at_max1, ovf0, ovf1, unf0, unf1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    cc_bank_stack #(.CC_W(CC_W), .LEVELS(LEVELS), .INHERIT(0)) u0 (
        .CLK(CLK), .RESET_N(RESET_N), .FETCH(FETCH), .CC_LD(CC_LD),
        .SEL_EN(SEL_EN), .CC_SEL(CC_SEL), .CCIN(CCIN),
        .INT_ENTER(INT_ENTER), .INT_EXIT(INT_EXIT), .CLR_ERR(CLR_ERR),
        .CCOUT(ccout0), .LEVEL(level0), .AT_MAX(at_max0), .OVF(ovf0), .UNF(unf0)
    );

    cc_bank_stack #(.CC_W(CC_W), .LEVELS(LEVELS), .INHERIT(1)) u1 (
        .CLK(CLK), .RESET_N(RESET_N), .FETCH(FETCH), .CC_LD(CC_LD),
        .SEL_EN(SEL_EN), .CC_SEL(CC_SEL), .CCIN(CCIN),
        .INT_ENTER(INT_ENTER), .INT_EXIT(INT_EXIT), .CLR_ERR(CLR_ERR),
        .CCOUT(ccout1), .LEVEL(level1), .AT_MAX(at_max1), .OVF(ovf1), .UNF(unf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then release all single-cycle controls.
    task automatic step();
        @(posedge CLK);
        #1;
        FETCH = 1'b0; CC_LD = 1'b0; INT_ENTER = 1'b0; INT_EXIT = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic wr(input logic [CC_W-1:0] d);
        FETCH = 1'b1; CC_LD = 1'b1; CCIN = d;
    endtask

    initial begin
        RESET_N = 1'b0; FETCH = 1'b0; CC_LD = 1'b0; SEL_EN = 1'b0; CC_SEL = '0;
        CCIN = '0; INT_ENTER = 1'b0; INT_EXIT = 1'b0; CLR_ERR = 1'b0;
        #12;
        check("rst_level", level0, 0);
        check("rst_ccout", ccout0, 0);
        check("rst_atmax", at_max0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_unf", unf0, 0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // 1: basic write, enter, write, exit
        wr(4'hA); step();
        check("t1_bank0", ccout0, 4'hA);
        INT_ENTER = 1'b1; step();
        check("t1_level1", level0, 1);
        check("t1_clear", ccout0, 4'h0);
        check("t1_inherit", ccout1, 4'hA);
        wr(4'h5); step();
        check("t1_bank1", ccout0, 4'h5);
        INT_EXIT = 1'b1; step();
        check("t1_exit_lvl", level0, 0);
        check("t1_exit_cc", ccout0, 4'hA);
        SEL_EN = 1'b1; CC_SEL = 2'd1; #1;
        check("t1_retained", ccout0, 4'h5);
        SEL_EN = 1'b0;

        // 2: entry on the same edge as a write to the outgoing bank
        wr(4'h3); step();
        check("t2_bank0", ccout1, 4'h3);
        wr(4'h9); INT_ENTER = 1'b1; step();
        check("t2_level", level1, 1);
        check("t2_bank1_inh", ccout1, 4'h9);
        check("t2_bank1_clr", ccout0, 4'h0);
        SEL_EN = 1'b1; CC_SEL = 2'd0; #1;
        check("t2_bank0_new", ccout1, 4'h9);
        SEL_EN = 1'b0;
        INT_EXIT = 1'b1; step();

        // 3: overflow and error clear
        INT_ENTER = 1'b1; step();
        check("t3_lvl1", level0, 1);
        check("t3_atmax0", at_max0, 0);
        INT_ENTER = 1'b1; step();
        check("t3_lvl2", level0, 2);
        check("t3_atmax1", at_max0, 1);
        INT_ENTER = 1'b1; step();
        check("t3_lvl_hold", level0, 2);
        check("t3_ovf", ovf0, 1);
        CLR_ERR = 1'b1; step();
        check("t3_ovf_clr", ovf0, 0);
        CLR_ERR = 1'b1; INT_ENTER = 1'b1; step();
        check("t3_set_wins", ovf0, 1);
        CLR_ERR = 1'b1; step();
        check("t3_ovf_clr2", ovf0, 0);

        // 4: underflow, simultaneous enter+exit
        INT_EXIT = 1'b1; step();
        INT_EXIT = 1'b1; step();
        check("t4_lvl0", level0, 0);
        check("t4_unf0", unf0, 0);
        INT_EXIT = 1'b1; step();
        check("t4_unf", unf0, 1);
        check("t4_lvl_hold", level0, 0);
        wr(4'h6); INT_ENTER = 1'b1; INT_EXIT = 1'b1; step();
        check("t4_both_lvl", level0, 0);
        check("t4_both_unf", unf0, 1);
        check("t4_both_ovf", ovf0, 0);
        check("t4_both_wr", ccout0, 4'h6);
        CLR_ERR = 1'b1; step();
        check("t4_unf_clr", unf0, 0);

        // 5: explicit select writes and out-of-range index
        INT_ENTER = 1'b1; step();
        INT_ENTER = 1'b1; step();
        wr(4'hC); step();
        check("t5_bank2", ccout0, 4'hC);
        SEL_EN = 1'b1; CC_SEL = 2'd0; wr(4'h7); step();
        check("t5_sel0", ccout0, 4'h7);
        SEL_EN = 1'b0; #1;
        check("t5_bank2_kept", ccout0, 4'hC);
        SEL_EN = 1'b1; CC_SEL = 2'd3; wr(4'hF); step();
        check("t5_oob_read", ccout0, 4'h0);
        SEL_EN = 1'b0; #1;
        check("t5_oob_bank2", ccout0, 4'hC);
        SEL_EN = 1'b1; CC_SEL = 2'd0; #1;
        check("t5_oob_bank0", ccout0, 4'h7);
        SEL_EN = 1'b0;

        // 6: write without FETCH, then async reset mid-cycle
        INT_ENTER = 1'b1; step();
        check("t6_ovf", ovf0, 1);
        CC_LD = 1'b1; CCIN = 4'h1; @(posedge CLK); #1; CC_LD = 1'b0;
        check("t6_nofetch", ccout0, 4'hC);
        #2; RESET_N = 1'b0; #1;
        check("t6_rst_lvl", level0, 0);
        check("t6_rst_ovf", ovf0, 0);
        check("t6_rst_cc", ccout0, 4'h0);
        SEL_EN = 1'b1; CC_SEL = 2'd0; #1;
        check("t6_rst_b0", ccout0, 4'h0);
        CC_SEL = 2'd2; #1;
        check("t6_rst_b2", ccout0, 4'h0);
        SEL_EN = 1'b0;
        @(negedge CLK); RESET_N = 1'b1;
        step();
        check("t6_post_lvl", level0, 0);
        check("t6_post_atmax", at_max0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
